// File: rtl/alu_issue_queue.sv
// ---------------------------------------------------------------------------
// alu_issue_queue
//
// Issue stage in front of a combinational ALU. Requests {op, a, b} go into a
// small FIFO. The head entry drives the ALU inputs. The ALU result, the zero
// flag and the producing opcode are then registered into a single output slot,
// which has a valid/ready handshake.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   flush             synchronous clear of the FIFO and the output slot
//   in_valid/in_ready request handshake (in_ready depends on count only)
//   in_op, in_a, in_b request payload
//   alu_op/a/b        head entry presented to the ALU (zeros when empty)
//   alu_result/zero   combinational ALU response
//   out_valid/ready   result slot handshake
//   out_result/zero/op registered result, zero flag and producing opcode
//   count             FIFO occupancy, not counting the output slot
// ---------------------------------------------------------------------------
module alu_issue_queue #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_zero,
    output logic [OP_W-1:0]   out_op,
    output logic [CNT_W-1:0]  count
);

    localparam int               PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Payload storage. The head is read combinationally because the ALU has to
    // see it in the same cycle that the result is captured.
    logic [OP_W-1:0]   mem_op [DEPTH];
    logic [DATA_W-1:0] mem_a  [DEPTH];
    logic [DATA_W-1:0] mem_b  [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;

    logic              out_valid_reg;
    logic [DATA_W-1:0] out_result_reg;
    logic              out_zero_reg;
    logic [OP_W-1:0]   out_op_reg;

    logic not_empty;
    logic slot_free;
    logic push;
    logic pop;

    assign not_empty = (count_reg != '0);
    assign slot_free = !out_valid_reg || out_ready;
    // in_ready is derived from count alone. A pop in the same cycle therefore
    // does not open the queue until the next cycle, and no comb path exists
    // from out_ready to in_ready.
    assign in_ready  = (count_reg < DEPTH_C);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = not_empty && slot_free && !flush;

    assign alu_op = not_empty ? mem_op[rd_ptr_reg] : '0;
    assign alu_a  = not_empty ? mem_a[rd_ptr_reg]  : '0;
    assign alu_b  = not_empty ? mem_b[rd_ptr_reg]  : '0;

    // Storage needs no reset: only entries that have been pushed are read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_op[wr_ptr_reg] <= in_op;
            mem_a[wr_ptr_reg]  <= in_a;
            mem_b[wr_ptr_reg]  <= in_b;
        end
    end

    // Pointers and occupancy. DEPTH is a power of two, so the natural
    // overflow of the pointer gives the modulo wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop && !push) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    // Output slot. The data registers keep their last values when the slot
    // drains or is flushed. Only out_valid is cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg  <= 1'b0;
            out_result_reg <= '0;
            out_zero_reg   <= 1'b0;
            out_op_reg     <= '0;
        end else if (flush) begin
            out_valid_reg <= 1'b0;
        end else if (pop) begin
            out_valid_reg  <= 1'b1;
            out_result_reg <= alu_result;
            out_zero_reg   <= alu_zero;
            out_op_reg     <= mem_op[rd_ptr_reg];
        end else if (out_valid_reg && out_ready) begin
            // Reached only when the FIFO is empty, because a non-empty FIFO
            // with a free slot would have taken the pop branch.
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid  = out_valid_reg;
    assign out_result = out_result_reg;
    assign out_zero   = out_zero_reg;
    assign out_op     = out_op_reg;
    assign count      = count_reg;

endmodule

// File: tb/tb_alu_issue_queue.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_queue
//
// Drives directed and random traffic through alu_issue_queue. An adder stub
// stands in for the ALU. A queue-based reference model holds the FIFO
// contents and the output slot.
// ---------------------------------------------------------------------------
module tb_alu_issue_queue;

    localparam int DATA_W = 32;
    localparam int OP_W   = 4;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 3;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_op;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic              out_zero;
    logic [OP_W-1:0]   out_op;
    logic [CNT_W-1:0]  count;

    alu_issue_queue #(
        .DATA_W(DATA_W), .OP_W(OP_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero), .out_op(out_op),
        .count(count)
    );

    // ALU stub: an adder that raises zero on a zero sum.
    assign alu_result = alu_a + alu_b;
    assign alu_zero   = (alu_result == '0);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } req_t;

    req_t              m_q[$];
    logic              m_ov;
    logic [DATA_W-1:0] m_res;
    logic              m_zero;
    logic [OP_W-1:0]   m_op;
    logic              last_acc;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ov   = 1'b0;
        m_res  = '0;
        m_zero = 1'b0;
        m_op   = '0;
    endtask

    // Compares every visible output against the model.
    task automatic check_all();
        logic [OP_W-1:0]   e_op;
        logic [DATA_W-1:0] e_a;
        logic [DATA_W-1:0] e_b;
        e_op = '0; e_a = '0; e_b = '0;
        if (m_q.size() > 0) begin
            e_op = m_q[0].op; e_a = m_q[0].a; e_b = m_q[0].b;
        end
        chk("out_valid",  {31'd0, out_valid}, {31'd0, m_ov});
        chk("out_result", out_result, m_res);
        chk("out_zero",   {31'd0, out_zero}, {31'd0, m_zero});
        chk("out_op",     {28'd0, out_op}, {28'd0, m_op});
        chk("count",      {29'd0, count}, 32'(m_q.size()));
        chk("in_ready",   {31'd0, in_ready}, {31'd0, (m_q.size() < DEPTH)});
        chk("alu_op",     {28'd0, alu_op}, {28'd0, e_op});
        chk("alu_a",      alu_a, e_a);
        chk("alu_b",      alu_b, e_b);
    endtask

    // One clock cycle: drive the inputs, advance the model across the edge,
    // then check 1 time unit after the edge.
    task automatic step(input logic v, input logic [OP_W-1:0] op,
                        input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                        input logic ordy, input logic fl);
        bit   do_push;
        bit   do_pop;
        req_t h;
        req_t n;
        in_valid  = v;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        out_ready = ordy;
        flush     = fl;
        do_push   = v && (m_q.size() < DEPTH) && !fl;
        do_pop    = (m_q.size() > 0) && (!m_ov || ordy) && !fl;
        n.op = op; n.a = a; n.b = b;
        @(posedge clk);
        if (fl) begin
            m_q.delete();
            m_ov = 1'b0;
        end else begin
            if (do_pop) begin
                h      = m_q.pop_front();
                m_res  = h.a + h.b;
                m_zero = (m_res == '0);
                m_op   = h.op;
                m_ov   = 1'b1;
            end else if (m_ov && ordy) begin
                m_ov = 1'b0;
            end
            if (do_push) m_q.push_back(n);
        end
        last_acc = do_push;
        #1;
        check_all();
        $display("step v=%0d op=%0d a=%h b=%h ordy=%0d fl=%0d acc=%0d | ov=%0d res=%h z=%0d cnt=%0d",
                 v, op, a, b, ordy, fl, last_acc, out_valid, out_result, out_zero, count);
    endtask

    initial begin
        logic [DATA_W-1:0] ra;
        int                i;
        int                guard;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = '0; in_a = '0; in_b = '0;
        model_reset();
        last_acc = 1'b0;

        // Reset state, before any clock edge.
        #1;
        check_all();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check_all();

        // Single op, with 1-edge latency.
        step(1, 4'd2, 32'd5, 32'd7, 1, 0);
        chk("single_pending", {31'd0, out_valid}, 32'd0);
        step(0, 0, 0, 0, 1, 0);
        chk("single_res", out_result, 32'h0000000C);
        chk("single_op", {28'd0, out_op}, 32'd2);
        step(0, 0, 0, 0, 1, 0);
        chk("single_drain", {31'd0, out_valid}, 32'd0);

        // Zero flag.
        step(1, 4'd1, 32'hFFFFFFFF, 32'd1, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("zero_res", out_result, 32'd0);
        chk("zero_flag", {31'd0, out_zero}, 32'd1);
        step(0, 0, 0, 0, 1, 0);

        // Backpressure, filling the FIFO.
        for (int k = 0; k < 5; k++) step(1, 4'(k + 3), 32'(100 + k), 32'd1, 0, 0);
        chk("full_count", {29'd0, count}, 32'd4);
        chk("full_ready", {31'd0, in_ready}, 32'd0);
        chk("full_slot", out_result, 32'd101);
        step(1, 4'd9, 32'd999, 32'd0, 0, 0);
        chk("full_reject", {31'd0, last_acc}, 32'd0);
        step(0, 0, 0, 0, 1, 0);
        chk("first_pop_ready", {31'd0, in_ready}, 32'd1);
        chk("first_pop_res", out_result, 32'd102);
        repeat (5) step(0, 0, 0, 0, 1, 0);

        // Wrap-around stream with out_ready toggling.
        i = 0; guard = 0;
        while (i < 10 && guard < 200) begin
            step(1, 4'd5, 32'(i), 32'd0, 1'(guard % 2), 0);
            if (last_acc) i++;
            guard++;
        end
        chk("wrap_all_pushed", 32'(i), 32'd10);
        repeat (12) step(0, 0, 0, 0, 1, 0);

        // Flush with three queued entries plus a full slot.
        for (int k = 0; k < 4; k++) step(1, 4'd6, 32'(200 + k), 32'd0, 0, 0);
        chk("pre_flush_count", {29'd0, count}, 32'd3);
        step(1, 4'd7, 32'd777, 32'd0, 0, 1);
        chk("flush_count", {29'd0, count}, 32'd0);
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        step(1, 4'd8, 32'd40, 32'd2, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("post_flush_res", out_result, 32'd42);
        step(0, 0, 0, 0, 1, 0);

        // Asynchronous reset between clock edges.
        step(1, 4'd3, 32'd10, 32'd1, 0, 0);
        step(1, 4'd3, 32'd20, 32'd1, 0, 0);
        step(1, 4'd3, 32'd30, 32'd1, 0, 0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("areset_valid", {31'd0, out_valid}, 32'd0);
        chk("areset_count", {29'd0, count}, 32'd0);
        check_all();
        #2 rst_n = 1'b1;
        step(1, 4'd4, 32'd1000, 32'd234, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("post_reset_res", out_result, 32'd1234);
        chk("post_reset_op", {28'd0, out_op}, 32'd4);

        // Random traffic.
        for (int k = 0; k < 300; k++) begin
            ra = $urandom;
            step(1'($urandom_range(0, 3) != 0), 4'($urandom), ra,
                 ($urandom_range(0, 4) == 0) ? -ra : 32'($urandom),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 30) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
